// File: rtl/vend_pkg.sv
// Shared vending-display definitions: display states, glyphs, default timing
// and the binary-to-BCD helpers used by the balance converter.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_BAL = 2'd0,
        ST_MSG = 2'd1,
        ST_ERR = 2'd2
    } disp_state_t;

    localparam logic [3:0] GLYPH_C = 4'hC;
    localparam logic [3:0] GLYPH_E = 4'hE;

    localparam int HOLD_MSG_DEF = 2000;
    localparam int HOLD_ERR_DEF = 1000;
    localparam int BLINK_DEF    = 250;

    localparam int BAL_W = 10;
    localparam int BCD_W = 12;
    localparam int SEG_W = 24;
    localparam int CNT_W = 16;

    localparam logic [BAL_W-1:0] BAL_MAX = 10'd999;

    // Clamp a captured balance to what three BCD digits can show.
    function automatic logic [BAL_W-1:0] sat_bal(input logic [BAL_W-1:0] v);
        return (v > BAL_MAX) ? BAL_MAX : v;
    endfunction

    // One shift-add-3 step on {bcd[11:0], bin[9:0]}.
    function automatic logic [BCD_W+BAL_W-1:0] dd_step(input logic [BCD_W+BAL_W-1:0] s);
        logic [BCD_W+BAL_W-1:0] t;
        t = s;
        for (int d = 0; d < 3; d++) begin
            t[BAL_W+4*d +: 4] = (t[BAL_W+4*d +: 4] >= 4'd5) ? (t[BAL_W+4*d +: 4] + 4'd3)
                                                           : t[BAL_W+4*d +: 4];
        end
        return {t[BCD_W+BAL_W-2:0], 1'b0};
    endfunction

    function automatic logic [SEG_W-1:0] bal_word(input logic [BCD_W-1:0] bcd);
        return {12'h000, bcd};
    endfunction

endpackage

// File: rtl/seg_sched_if.sv
// Request/display bundle between the vending controller and the display scheduler.
interface seg_sched_if
    import vend_pkg::*;
;
    logic [BAL_W-1:0] bal;
    logic             bal_vld;
    logic             msg_req;
    logic [3:0]       msg_code;
    logic             err_req;
    logic [SEG_W-1:0] seg_in;
    logic             msg_ack;
    logic             conv_busy;

    modport master (
        output bal, bal_vld, msg_req, msg_code, err_req,
        input  seg_in, msg_ack, conv_busy
    );

    modport slave (
        input  bal, bal_vld, msg_req, msg_code, err_req,
        output seg_in, msg_ack, conv_busy
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 10-bit binary to 3-digit BCD converter, one shift-add-3 step per tick.
// The first shift happens on the capture tick; done is high in the tick after the tenth shift.
module bin2bcd_seq
    import vend_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_start,
    input  logic [BAL_W-1:0] i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);

    logic [BCD_W+BAL_W-1:0] r_sh;
    logic [3:0]             r_cnt;
    logic                   r_busy;

    // Capture, shift and retire one conversion.
    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            r_sh   <= '0;
            r_cnt  <= 4'd0;
            r_busy <= 1'b0;
        end else if (!r_busy) begin
            if (i_start) begin
                r_sh   <= dd_step({12'h000, sat_bal(i_bin)});
                r_cnt  <= 4'd1;
                r_busy <= 1'b1;
            end else begin
                r_cnt  <= 4'd0;
            end
        end else if (r_cnt != 4'd10) begin
            r_sh  <= dd_step(r_sh);
            r_cnt <= r_cnt + 4'd1;
        end else begin
            r_busy <= 1'b0;
            r_cnt  <= 4'd0;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == 4'd10);
    assign o_bcd  = r_sh[BCD_W+BAL_W-1:BAL_W];

endmodule

// File: rtl/seg_sched.sv
// Display scheduler: arbitrates balance, message and error views (ERR > MSG > BAL)
// and drives a registered six-nibble word to the 7-segment scanner.
module seg_sched
    import vend_pkg::*;
#(
    parameter int HOLD_MSG = HOLD_MSG_DEF,
    parameter int HOLD_ERR = HOLD_ERR_DEF,
    parameter int BLINK    = BLINK_DEF
) (
    input  logic        clk1k,
    input  logic        clr,
    seg_sched_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_MSG_LD = CNT_W'(HOLD_MSG - 1);
    localparam logic [CNT_W-1:0] HOLD_ERR_LD = CNT_W'(HOLD_ERR - 1);
    localparam logic [CNT_W-1:0] BLINK_LD    = CNT_W'(BLINK - 1);

    disp_state_t      r_state;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] r_blink;
    logic             r_phase_on;
    logic [3:0]       r_code;
    logic             r_pmsg_vld;
    logic [3:0]       r_pmsg_code;
    logic             r_msg_ack;
    logic [SEG_W-1:0] r_seg_in;

    logic             r_pend_vld;
    logic [BAL_W-1:0] r_pend_val;
    logic [BCD_W-1:0] r_bal_bcd;

    logic             w_busy;
    logic             w_done;
    logic             w_start;
    logic [BAL_W-1:0] w_start_val;
    logic [BCD_W-1:0] w_bcd;

    // A fresh bal_vld overrides anything still waiting in the pending slot.
    assign w_start     = !w_busy && (bus.bal_vld || r_pend_vld);
    assign w_start_val = bus.bal_vld ? bus.bal : r_pend_val;

    bin2bcd_seq u_bcd (
        .i_clk   (clk1k),
        .i_clr   (clr),
        .i_start (w_start),
        .i_bin   (w_start_val),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    // Pending balance slot and the displayed BCD balance.
    always_ff @(posedge clk1k or negedge clr) begin
        if (!clr) begin
            r_pend_vld <= 1'b0;
            r_pend_val <= '0;
            r_bal_bcd  <= '0;
        end else begin
            if (bus.bal_vld && w_busy) begin
                r_pend_vld <= 1'b1;
                r_pend_val <= bus.bal;
            end else if (w_start) begin
                r_pend_vld <= 1'b0;
            end else begin
                r_pend_vld <= r_pend_vld;
            end
            if (w_done) begin
                r_bal_bcd <= w_bcd;
            end else begin
                r_bal_bcd <= r_bal_bcd;
            end
        end
    end

    // Display state machine with registered ack and display word.
    always_ff @(posedge clk1k or negedge clr) begin
        if (!clr) begin
            r_state     <= ST_BAL;
            r_hold      <= '0;
            r_blink     <= '0;
            r_phase_on  <= 1'b1;
            r_code      <= 4'h0;
            r_pmsg_vld  <= 1'b0;
            r_pmsg_code <= 4'h0;
            r_msg_ack   <= 1'b0;
            r_seg_in    <= '0;
        end else begin
            r_msg_ack <= 1'b0;
            case (r_state)
                ST_BAL: begin
                    if (bus.err_req) begin
                        r_state    <= ST_ERR;
                        r_hold     <= HOLD_ERR_LD;
                        r_blink    <= BLINK_LD;
                        r_phase_on <= 1'b1;
                        if (bus.msg_req) begin
                            r_pmsg_vld  <= 1'b1;
                            r_pmsg_code <= bus.msg_code;
                            r_msg_ack   <= 1'b1;
                        end else begin
                            r_pmsg_vld  <= r_pmsg_vld;
                        end
                    end else if (bus.msg_req) begin
                        r_state   <= ST_MSG;
                        r_code    <= bus.msg_code;
                        r_hold    <= HOLD_MSG_LD;
                        r_msg_ack <= 1'b1;
                    end else begin
                        r_state <= ST_BAL;
                    end
                end
                ST_MSG: begin
                    if (bus.err_req) begin
                        // The preempted (or just-requested) message waits out the error.
                        r_state     <= ST_ERR;
                        r_hold      <= HOLD_ERR_LD;
                        r_blink     <= BLINK_LD;
                        r_phase_on  <= 1'b1;
                        r_pmsg_vld  <= 1'b1;
                        r_pmsg_code <= bus.msg_req ? bus.msg_code : r_code;
                        r_msg_ack   <= bus.msg_req;
                    end else if (bus.msg_req) begin
                        r_code    <= bus.msg_code;
                        r_hold    <= HOLD_MSG_LD;
                        r_msg_ack <= 1'b1;
                    end else if (r_hold == '0) begin
                        r_state <= ST_BAL;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                ST_ERR: begin
                    if (r_blink == '0) begin
                        r_blink    <= BLINK_LD;
                        r_phase_on <= !r_phase_on;
                    end else begin
                        r_blink <= r_blink - 1'b1;
                    end
                    if (!bus.err_req && (r_hold == '0)) begin
                        r_pmsg_vld <= 1'b0;
                        if (bus.msg_req) begin
                            r_state   <= ST_MSG;
                            r_code    <= bus.msg_code;
                            r_hold    <= HOLD_MSG_LD;
                            r_msg_ack <= 1'b1;
                        end else if (r_pmsg_vld) begin
                            r_state <= ST_MSG;
                            r_code  <= r_pmsg_code;
                            r_hold  <= HOLD_MSG_LD;
                        end else begin
                            r_state <= ST_BAL;
                        end
                    end else begin
                        r_hold <= (r_hold != '0) ? (r_hold - 1'b1) : r_hold;
                        if (bus.msg_req) begin
                            r_pmsg_vld  <= 1'b1;
                            r_pmsg_code <= bus.msg_code;
                            r_msg_ack   <= 1'b1;
                        end else begin
                            r_pmsg_vld  <= r_pmsg_vld;
                        end
                    end
                end
                default: begin
                    r_state <= ST_BAL;
                end
            endcase

            case (r_state)
                ST_BAL:  r_seg_in <= bal_word(r_bal_bcd);
                ST_MSG:  r_seg_in <= {4'h0, GLYPH_C, 12'h000, r_code};
                ST_ERR:  r_seg_in <= r_phase_on ? {4'h0, {5{GLYPH_E}}} : bal_word(r_bal_bcd);
                default: r_seg_in <= 24'h000000;
            endcase
        end
    end

    assign bus.seg_in    = r_seg_in;
    assign bus.msg_ack   = r_msg_ack;
    assign bus.conv_busy = w_busy;

endmodule

// File: tb/tb_seg_sched.sv
// Scoreboard bench for seg_sched: expected display words (and segment lengths)
// are queued as stimulus is applied and matched whenever seg_in changes.
module tb_seg_sched;

    typedef struct {
        logic [23:0] val;
        int          lmin;
        int          lmax;
    } exp_t;

    logic clk1k = 1'b0;
    logic clr   = 1'b0;
    seg_sched_if bus ();

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    logic [23:0] cur_val  = 24'h000000;
    int          cur_start = 0;
    int          cur_lmin  = 0;
    int          cur_lmax  = 0;

    seg_sched dut (
        .clk1k (clk1k),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk1k = ~clk1k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk1k);
        #1;
    endtask

    task automatic push(input logic [23:0] v, input int lmin, input int lmax);
        exp_t e;
        e.val  = v;
        e.lmin = lmin;
        e.lmax = lmax;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string tag, input int bound);
        int n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, sb_q.size(), 0);
    endtask

    task automatic send_bal(input logic [9:0] v);
        bus.bal     = v;
        bus.bal_vld = 1'b1;
        tick();
        bus.bal_vld = 1'b0;
    endtask

    // Monitor: every change of seg_in is matched against the scoreboard.
    always @(negedge clk1k) begin
        exp_t e;
        int   len;
        cyc++;
        if (bus.seg_in !== cur_val) begin
            len = cyc - cur_start;
            if (cur_lmax != 0)
                chk("seg_len", (len >= cur_lmin && len <= cur_lmax) ? cur_lmin : len, cur_lmin);
            if (sb_q.size() == 0) begin
                chk("seg_unexpected", bus.seg_in, cur_val);
                cur_lmin = 0;
                cur_lmax = 0;
            end else begin
                e = sb_q.pop_front();
                chk("seg_word", bus.seg_in, e.val);
                cur_lmin = e.lmin;
                cur_lmax = e.lmax;
            end
            cur_val   = bus.seg_in;
            cur_start = cyc;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.bal      = 10'd0;
        bus.bal_vld  = 1'b0;
        bus.msg_req  = 1'b0;
        bus.msg_code = 4'h0;
        bus.err_req  = 1'b0;
        repeat (3) tick();
        chk("rst_seg", bus.seg_in, 24'h000000);
        chk("rst_ack", bus.msg_ack, 1'b0);
        chk("rst_busy", bus.conv_busy, 1'b0);
        clr = 1'b1;
        repeat (2) tick();

        // 357: busy for exactly 10 ticks, then the BAL word.
        push(24'h000357, 0, 0);
        send_bal(10'd357);
        n = 0;
        while (bus.conv_busy && n < 40) begin
            n++;
            tick();
        end
        chk("busy_len", n, 10);
        drain("sb_357", 20);

        // Saturation.
        push(24'h000999, 0, 0);
        send_bal(10'd1023);
        drain("sb_1023", 30);

        // Back-to-back: second value waits in the pending slot.
        push(24'h000123, 10, 11);
        push(24'h000456, 0, 0);
        send_bal(10'd123);
        repeat (4) tick();
        send_bal(10'd456);
        drain("sb_123_456", 60);

        push(24'h000999, 0, 0);
        send_bal(10'd999);
        drain("sb_999", 30);

        // Message display for 2000 ticks.
        push(24'h0C0005, 2000, 2000);
        push(24'h000999, 0, 0);
        bus.msg_code = 4'h5;
        bus.msg_req  = 1'b1;
        tick();
        bus.msg_req  = 1'b0;
        chk("ack_msg5", bus.msg_ack, 1'b1);
        tick();
        chk("ack_msg5_end", bus.msg_ack, 1'b0);
        drain("sb_msg5", 2100);

        // Error and message in the same tick: blink, then the deferred message.
        push(24'h0EEEEE, 250, 250);
        push(24'h000999, 250, 250);
        push(24'h0EEEEE, 250, 250);
        push(24'h000999, 250, 250);
        push(24'h0C0003, 2000, 2000);
        push(24'h000999, 0, 0);
        bus.err_req  = 1'b1;
        bus.msg_code = 4'h3;
        bus.msg_req  = 1'b1;
        tick();
        bus.msg_req  = 1'b0;
        chk("ack_err_msg3", bus.msg_ack, 1'b1);
        repeat (299) tick();
        bus.err_req  = 1'b0;
        drain("sb_err", 3200);

        // Reset during a message hold.
        push(24'h0C0007, 0, 0);
        bus.msg_code = 4'h7;
        bus.msg_req  = 1'b1;
        tick();
        bus.msg_req  = 1'b0;
        drain("sb_msg7", 10);
        repeat (50) tick();
        push(24'h000000, 0, 0);
        clr = 1'b0;
        #1;
        chk("clr_seg", bus.seg_in, 24'h000000);
        chk("clr_ack", bus.msg_ack, 1'b0);
        repeat (2) tick();
        clr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_clr_ack", bus.msg_ack, 1'b0);
        end
        chk("post_clr_seg", bus.seg_in, 24'h000000);
        drain("sb_clr", 5);

        // Reset during a conversion: no result may appear afterwards.
        send_bal(10'd500);
        repeat (4) tick();
        clr = 1'b0;
        tick();
        clr = 1'b1;
        repeat (15) tick();
        chk("abort_busy", bus.conv_busy, 1'b0);
        chk("abort_seg", bus.seg_in, 24'h000000);

        // Display back in BAL after reset.
        push(24'h000042, 0, 0);
        send_bal(10'd42);
        drain("sb_42", 30);
        repeat (5) tick();
        chk("sb_left", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
